anton_neopixel_frame_loader: RTL and testbench



---
 rtl/anton_neopixel_frame_loader.sv | 206 ++++++++++++++++++++
 tb/tb_anton_neopixel_frame_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_frame_loader.sv
// ---------------------------------------------------------------------------
// anton_neopixel_frame_loader
//
// Upstream bus master for the neopixel module. It takes one pixel frame as a
// byte stream over a valid/ready handshake and writes the bytes in order into
// the pixel buffer, starting at address 0. At the end of the frame it writes
// the max register (index of the last pixel byte, low then high byte) and then
// the control register. frameDone pulses together with the control write.
// Bytes past the end of the buffer are dropped and raise the sticky overflow
// flag.
//
// Ports
//   busClk     in   1  single clock; shared with the neopixel bus
//   reset      in   1  synchronous, active-high reset
//   inData     in   8  frame byte
//   inValid    in   1  inData/inLast valid
//   inLast     in   1  marks the final byte of the frame
//   inReady    out  1  loader accepts a byte this cycle
//   ctrlByte   in   8  control value, latched on the first byte of a frame
//   busAddr    out 14  write address to the neopixel module
//   busDataOut out  8  write data (neopixel busDataIn)
//   busWrite   out  1  one-cycle write strobe
//   busy       out  1  high from the first accepted byte until frameDone
//   frameDone  out  1  one-cycle pulse with the control-register write
//   overflow   out  1  sticky: the frame was longer than the buffer
// ---------------------------------------------------------------------------

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 767
`endif

module anton_neopixel_frame_loader #(
    parameter int          BUFFER_END     = `BUFFER_END_DEFAULT,
    parameter logic [13:0] REG_MAX_L_ADDR = 14'h2000,
    parameter logic [13:0] REG_MAX_H_ADDR = 14'h2001,
    parameter logic [13:0] REG_CTRL_ADDR  = 14'h2002
) (
    input  logic        busClk,
    input  logic        reset,
    input  logic [7:0]  inData,
    input  logic        inValid,
    input  logic        inLast,
    output logic        inReady,
    input  logic [7:0]  ctrlByte,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataOut,
    output logic        busWrite,
    output logic        busy,
    output logic        frameDone,
    output logic        overflow
);

    localparam int BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
    localparam logic [BUFFER_BITS-1:0] LAST_INDEX = BUFFER_BITS'(BUFFER_END);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WR_MAX_L,
        WR_MAX_H,
        WR_CTRL
    } stateType;

    stateType               state, stateNext;
    logic [BUFFER_BITS-1:0] index, indexNext;       // next buffer address to write
    logic [BUFFER_BITS-1:0] lastAddr, lastAddrNext; // address of the last byte written
    logic [7:0]             ctrlLatched, ctrlLatchedNext;
    logic [13:0]            busAddrNext;
    logic [7:0]             busDataNext;
    logic                   busWriteNext;
    logic                   busyNext;
    logic                   frameDoneNext;
    logic                   overflowNext;
    logic                   transfer;
    logic [12:0]            maxVal;

    // The loader only stalls while it emits the three register writes.
    assign inReady  = (state == IDLE) || (state == LOAD) || (state == DRAIN);
    assign transfer = inValid && inReady;
    assign maxVal   = 13'(lastAddr);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge; blocking here would let one
    // register see another's new value and break the one-cycle bus latency.
    always_ff @(posedge busClk) begin
        if (reset) begin
            state       <= IDLE;
            index       <= '0;
            lastAddr    <= '0;
            ctrlLatched <= '0;
            busAddr     <= '0;
            busDataOut  <= '0;
            busWrite    <= 1'b0;
            busy        <= 1'b0;
            frameDone   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= stateNext;
            index       <= indexNext;
            lastAddr    <= lastAddrNext;
            ctrlLatched <= ctrlLatchedNext;
            busAddr     <= busAddrNext;
            busDataOut  <= busDataNext;
            busWrite    <= busWriteNext;
            busy        <= busyNext;
            frameDone   <= frameDoneNext;
            overflow    <= overflowNext;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path through the block leaves a value unassigned and no latch is
    // inferred. Defaulting the bus address/data to their current values is what
    // makes them hold while busWrite is low.
    always_comb begin
        stateNext       = state;
        indexNext       = index;
        lastAddrNext    = lastAddr;
        ctrlLatchedNext = ctrlLatched;
        busAddrNext     = busAddr;
        busDataNext     = busDataOut;
        busWriteNext    = 1'b0;
        frameDoneNext   = 1'b0;
        overflowNext    = overflow;
        // busy stays up through the frameDone cycle and drops right after,
        // unless the next frame's first byte is accepted in that same cycle.
        busyNext        = busy && !frameDone;

        case (state)
            IDLE: begin
                if (transfer) begin
                    ctrlLatchedNext = ctrlByte;
                    overflowNext    = 1'b0;
                    busyNext        = 1'b1;
                    busAddrNext     = '0;
                    busDataNext     = inData;
                    busWriteNext    = 1'b1;
                    lastAddrNext    = '0;
                    indexNext       = BUFFER_BITS'(1);
                    if (inLast) begin
                        stateNext = WR_MAX_L;
                    end else if (LAST_INDEX == '0) begin
                        // One-byte buffer: the first byte already fills it.
                        overflowNext = 1'b1;
                        stateNext    = DRAIN;
                    end else begin
                        stateNext = LOAD;
                    end
                end
            end

            LOAD: begin
                if (transfer) begin
                    busAddrNext  = 14'(index);
                    busDataNext  = inData;
                    busWriteNext = 1'b1;
                    lastAddrNext = index;
                    indexNext    = index + 1'b1;
                    if (inLast) begin
                        stateNext = WR_MAX_L;
                    end else if (index == LAST_INDEX) begin
                        // Buffer full and the frame keeps going.
                        overflowNext = 1'b1;
                        stateNext    = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Swallow the rest of an oversized frame without writing it.
                if (transfer && inLast) begin
                    stateNext = WR_MAX_L;
                end
            end

            WR_MAX_L: begin
                busAddrNext  = REG_MAX_L_ADDR;
                busDataNext  = maxVal[7:0];
                busWriteNext = 1'b1;
                stateNext    = WR_MAX_H;
            end

            WR_MAX_H: begin
                busAddrNext  = REG_MAX_H_ADDR;
                busDataNext  = {3'b000, maxVal[12:8]};
                busWriteNext = 1'b1;
                stateNext    = WR_CTRL;
            end

            WR_CTRL: begin
                busAddrNext   = REG_CTRL_ADDR;
                busDataNext   = ctrlLatched;
                busWriteNext  = 1'b1;
                frameDoneNext = 1'b1;
                indexNext     = '0;
                stateNext     = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_anton_neopixel_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_anton_neopixel_frame_loader
//
// Directed stimulus for the frame loader with BUFFER_END = 7. A frame-level
// model turns every accepted byte into the bus writes it must cause (buffer
// write one cycle later, then MAX_L/MAX_H/CTRL writes after the last byte) and
// keeps the expected handshake/status flags. One compare process checks the
// DUT against that model on every cycle, and also against a queue of
// hand-written bus writes for the first three frames.
// ---------------------------------------------------------------------------

module tb_anton_neopixel_frame_loader;

    localparam int BE = 7;

    logic        busClk   = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  inData   = 8'h00;
    logic        inValid  = 1'b0;
    logic        inLast   = 1'b0;
    logic        inReady;
    logic [7:0]  ctrlByte = 8'h00;
    logic [13:0] busAddr;
    logic [7:0]  busDataOut;
    logic        busWrite;
    logic        busy;
    logic        frameDone;
    logic        overflow;

    anton_neopixel_frame_loader #(
        .BUFFER_END(BE)
    ) dut (
        .busClk    (busClk),
        .reset     (reset),
        .inData    (inData),
        .inValid   (inValid),
        .inLast    (inLast),
        .inReady   (inReady),
        .ctrlByte  (ctrlByte),
        .busAddr   (busAddr),
        .busDataOut(busDataOut),
        .busWrite  (busWrite),
        .busy      (busy),
        .frameDone (frameDone),
        .overflow  (overflow)
    );

    always #5 busClk = ~busClk;

    // Counters
    int checks = 0;
    int errors = 0;

    // Model: expected bus writes and frameDone pulses keyed by cycle number.
    logic [21:0] expWr   [int];
    bit          expDone [int];
    int          cyc       = 0;
    bit          armed     = 1'b0;
    bit          mReady    = 1'b1;
    bit          mBusy     = 1'b0;
    bit          mOverflow = 1'b0;
    logic [13:0] mAddr     = '0;
    logic [7:0]  mData     = '0;
    logic [7:0]  frameCtrl = '0;
    int          count     = 0;   // bytes accepted so far in the current frame
    int          readyAt   = 0;   // first cycle the loader takes bytes again
    int          mv        = 0;

    // Hand-written writes: {overflow, frameDone, addr, data}.
    logic [23:0] litQ[$];
    int          litIdx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare process, then model update with this cycle's inputs.
    initial begin
        forever begin
            @(negedge busClk);
            if (armed) begin
                if (expWr.exists(cyc)) begin
                    mAddr = expWr[cyc][21:8];
                    mData = expWr[cyc][7:0];
                end
                check("inReady",    32'(inReady),    32'(mReady));
                check("busy",       32'(busy),       32'(mBusy));
                check("overflow",   32'(overflow),   32'(mOverflow));
                check("frameDone",  32'(frameDone),  32'(expDone.exists(cyc)));
                check("busWrite",   32'(busWrite),   32'(expWr.exists(cyc)));
                check("busAddr",    32'(busAddr),    32'(mAddr));
                check("busDataOut", 32'(busDataOut), 32'(mData));
                if (busWrite === 1'b1 && litIdx < litQ.size()) begin
                    check("lit_addr",      32'(busAddr),    32'(litQ[litIdx][21:8]));
                    check("lit_data",      32'(busDataOut), 32'(litQ[litIdx][7:0]));
                    check("lit_frameDone", 32'(frameDone),  32'(litQ[litIdx][22]));
                    check("lit_overflow",  32'(overflow),   32'(litQ[litIdx][23]));
                    litIdx++;
                end
            end

            if (reset) begin
                // Everything pending is abandoned; outputs return to reset values.
                expWr.delete();
                expDone.delete();
                mReady    = 1'b1;
                mBusy     = 1'b0;
                mOverflow = 1'b0;
                mAddr     = '0;
                mData     = '0;
                frameCtrl = '0;
                count     = 0;
                readyAt   = 0;
                armed     = 1'b1;
            end else begin
                if (expDone.exists(cyc)) mBusy = 1'b0;
                if (inValid && mReady) begin
                    if (count == 0) begin
                        frameCtrl = ctrlByte;
                        mOverflow = 1'b0;
                        mBusy     = 1'b1;
                    end
                    if (count <= BE) expWr[cyc + 1] = {14'(count), inData};
                    if (count == BE && !inLast) mOverflow = 1'b1;
                    if (inLast) begin
                        mv = (count < BE) ? count : BE;
                        expWr[cyc + 2]   = {14'h2000, 8'(mv)};
                        expWr[cyc + 3]   = {14'h2001, 8'(mv >> 8)};
                        expWr[cyc + 4]   = {14'h2002, frameCtrl};
                        expDone[cyc + 4] = 1'b1;
                        readyAt = cyc + 4;
                        count   = 0;
                    end else begin
                        count++;
                    end
                end
                mReady = (cyc + 1 >= readyAt);
            end
            cyc++;
        end
    end

    task automatic sendByte(input logic [7:0] d, input logic last, input logic [7:0] c);
        bit accepted;
        accepted = 1'b0;
        inData   = d;
        inLast   = last;
        inValid  = 1'b1;
        ctrlByte = c;
        for (int i = 0; i < 20; i++) begin
            @(negedge busClk);
            if (inReady === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            $display("FAIL inReady_timeout: byte %0h never accepted (got inReady=%b, expected 1)", d, inReady);
            $fatal(1, "loader stalled");
        end
        @(posedge busClk);
        #1;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        inLast  = 1'b0;
        repeat (n) begin
            @(posedge busClk);
            #1;
        end
    endtask

    task automatic pushLit(input logic ovf, input logic done, input logic [13:0] a, input logic [7:0] d);
        litQ.push_back({ovf, done, a, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frame 1: AA BB CC, ctrl 05
        pushLit(0, 0, 14'h0000, 8'hAA);
        pushLit(0, 0, 14'h0001, 8'hBB);
        pushLit(0, 0, 14'h0002, 8'hCC);
        pushLit(0, 0, 14'h2000, 8'h02);
        pushLit(0, 0, 14'h2001, 8'h00);
        pushLit(0, 1, 14'h2002, 8'h05);
        // Frame 2: single byte 11, ctrl 3C
        pushLit(0, 0, 14'h0000, 8'h11);
        pushLit(0, 0, 14'h2000, 8'h00);
        pushLit(0, 0, 14'h2001, 8'h00);
        pushLit(0, 1, 14'h2002, 8'h3C);
        // Frame 3: ten bytes 10..19, ctrl 81; only 0..7 land, overflow from byte 7
        for (int i = 0; i < 7; i++) pushLit(0, 0, 14'(i), 8'(16 + i));
        pushLit(1, 0, 14'h0007, 8'h17);
        pushLit(1, 0, 14'h2000, 8'h07);
        pushLit(1, 0, 14'h2001, 8'h00);
        pushLit(1, 1, 14'h2002, 8'h81);

        repeat (2) @(posedge busClk);
        #1;
        reset = 1'b0;
        idle(2);

        sendByte(8'hAA, 1'b0, 8'h05);
        sendByte(8'hBB, 1'b0, 8'h05);
        sendByte(8'hCC, 1'b1, 8'h05);
        idle(6);

        sendByte(8'h11, 1'b1, 8'h3C);
        idle(6);

        // ctrlByte changes after the first byte must be ignored
        for (int i = 0; i < 10; i++) sendByte(8'(16 + i), i == 9, (i == 0) ? 8'h81 : 8'hFF);
        idle(6);

        // Back-to-back frames with inValid held high
        sendByte(8'h01, 1'b0, 8'h44);
        sendByte(8'h02, 1'b1, 8'h44);
        sendByte(8'h03, 1'b0, 8'h55);
        sendByte(8'h04, 1'b0, 8'h55);
        sendByte(8'h05, 1'b1, 8'h55);
        idle(6);

        // inValid toggling within a frame
        sendByte(8'hA0, 1'b0, 8'h66);
        idle(1);
        sendByte(8'hA1, 1'b0, 8'h77);
        idle(2);
        sendByte(8'hA2, 1'b0, 8'h77);
        sendByte(8'hA3, 1'b1, 8'h77);
        idle(6);

        // Exactly BUFFER_END+1 bytes: full buffer, no overflow
        for (int i = 0; i <= BE; i++) sendByte(8'(8'h60 + i), i == BE, 8'h2A);
        idle(6);

        // Reset after the second byte, with a third byte offered during reset
        sendByte(8'hB0, 1'b0, 8'h99);
        sendByte(8'hB1, 1'b0, 8'h99);
        inData  = 8'hB2;
        inValid = 1'b1;
        reset   = 1'b1;
        repeat (2) begin
            @(posedge busClk);
            #1;
        end
        reset   = 1'b0;
        inValid = 1'b0;
        idle(3);
        sendByte(8'hC0, 1'b0, 8'h12);
        sendByte(8'hC1, 1'b1, 8'h12);
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
